// File: rtl/btn_debouncer_pkg.sv
// Shared definitions for the push-button input conditioner: defaults and
// per-channel debounce state encoding.
package btn_debouncer_pkg;

    localparam int unsigned N_BTN_DEF           = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'b00,
        ST_WAIT_PRESS   = 2'b01,
        ST_PRESSED      = 2'b10,
        ST_WAIT_RELEASE = 2'b11
    } db_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchronizer, debounce FSM with stability counter,
// registered level and one-cycle press/release pulses.
module debounce_channel
    import btn_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic i_ck_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    always_ff @(posedge clock or negedge i_ck_reset) begin
        if (!i_ck_reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= i_btn;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clock or negedge i_ck_reset) begin
        if (!i_ck_reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            o_level   <= level_nxt;
            o_press   <= press_nxt;
            o_release <= release_nxt;
        end
    end

    // The counter only runs in the WAIT states and is cleared on every exit,
    // so it can never pass CNT_LAST.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = o_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sync_q2) begin
                    state_nxt = ST_WAIT_PRESS;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_PRESS: begin
                if (!sync_q2) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!sync_q2) begin
                    state_nxt = ST_WAIT_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_RELEASE: begin
                if (sync_q2) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/btn_debouncer.sv
// Push-button conditioner: N_BTN independent debounce channels feeding the
// mode/color control logic with clean levels and press/release pulses.
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int unsigned N_BTN           = N_BTN_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             i_ck_reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_btn_level,
    output logic [N_BTN-1:0] o_btn_press,
    output logic [N_BTN-1:0] o_btn_release
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clock     (clock),
            .i_ck_reset(i_ck_reset),
            .i_btn     (i_btn[g]),
            .o_level   (o_btn_level[g]),
            .o_press   (o_btn_press[g]),
            .o_release (o_btn_release[g])
        );
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Bench for btn_debouncer with DEBOUNCE_CYCLES=4: directed vector table,
// hand-written corner sequences and randomized traffic against a window model.
module tb_btn_debouncer;

    localparam int unsigned NB = 4;
    localparam int unsigned DC = 4;
    localparam int unsigned HL = DC + 3;

    logic          clock;
    logic          i_ck_reset;
    logic [NB-1:0] i_btn;
    logic [NB-1:0] o_btn_level;
    logic [NB-1:0] o_btn_press;
    logic [NB-1:0] o_btn_release;

    int checks;
    int errors;

    btn_debouncer #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clock        (clock),
        .i_ck_reset   (i_ck_reset),
        .i_btn        (i_btn),
        .o_btn_level  (o_btn_level),
        .o_btn_press  (o_btn_press),
        .o_btn_release(o_btn_release)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: raw samples per edge; the FSM sees the sample taken two edges
    // earlier, and a level flips once DC+1 consecutive seen samples disagree.
    logic [NB-1:0] hist [HL];
    logic [NB-1:0] m_level;
    logic [NB-1:0] m_press;
    logic [NB-1:0] m_release;

    task automatic model_reset();
        for (int k = 0; k < HL; k++) hist[k] = '0;
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
    endtask

    task automatic model_edge(input logic [NB-1:0] raw);
        logic all_diff;
        for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0]   = raw;
        m_press   = '0;
        m_release = '0;
        for (int c = 0; c < NB; c++) begin
            all_diff = 1'b1;
            for (int k = 2; k < HL; k++)
                if (hist[k][c] == m_level[c]) all_diff = 1'b0;
            if (all_diff) begin
                if (m_level[c]) m_release[c] = 1'b1;
                else            m_press[c]   = 1'b1;
                m_level[c] = ~m_level[c];
            end
        end
    endtask

    task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Drive on the falling edge, let the rising edge sample, compare 1 ns later.
    task automatic step(input logic rst, input logic [NB-1:0] b);
        @(negedge clock);
        i_ck_reset = rst;
        i_btn      = b;
        @(posedge clock);
        if (!rst) model_reset();
        else      model_edge(b);
        #1;
        chk("model_level",   o_btn_level,   m_level);
        chk("model_press",   o_btn_press,   m_press);
        chk("model_release", o_btn_release, m_release);
        chk("press_and_release", o_btn_press & o_btn_release, '0);
    endtask

    typedef struct {
        logic          rst_n;
        logic [NB-1:0] btn;
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [NB-1:0] b, input logic [NB-1:0] l,
                       input logic [NB-1:0] p, input logic [NB-1:0] q, input int n);
        vec_t v;
        v.rst_n = r; v.btn = b; v.lvl = l; v.prs = p; v.rel = q;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Hold one input for 8 edges: unchanged for 6, flip with pulse on the 7th, pulse gone on the 8th.
    task automatic add_change(input logic [NB-1:0] b, input logic [NB-1:0] old_l,
                              input logic [NB-1:0] new_l, input logic [NB-1:0] p,
                              input logic [NB-1:0] q);
        add(1'b1, b, old_l, '0, '0, 6);
        add(1'b1, b, new_l, p,  q,  1);
        add(1'b1, b, new_l, '0, '0, 1);
    endtask

    task automatic hold(input logic [NB-1:0] b, input int n);
        for (int i = 0; i < n; i++) step(1'b1, b);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        i_ck_reset = 1'b0;
        i_btn      = '0;
        model_reset();

        // Reset with all buttons held, clean press/release, simultaneous channels
        add(1'b0, 4'b1111, '0, '0, '0, 3);
        add_change(4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
        add_change(4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        add_change(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        add_change(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        add_change(4'b1001, 4'b0000, 4'b1001, 4'b1001, 4'b0000);
        add_change(4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b1001);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].btn);
            chk($sformatf("tbl%0d_level", i),   o_btn_level,   vecs[i].lvl);
            chk($sformatf("tbl%0d_press", i),   o_btn_press,   vecs[i].prs);
            chk($sformatf("tbl%0d_release", i), o_btn_release, vecs[i].rel);
        end

        // Bounce on channel 1: 2-cycle runs never qualify
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 2; i++) begin
                step(1'b1, (r % 2 == 0) ? 4'b0010 : 4'b0000);
                chk("bounce_press", o_btn_press, '0);
                chk("bounce_level", o_btn_level, '0);
            end
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 4'b0010);
            chk($sformatf("bounce_hold%0d_press", i), o_btn_press, (i == 7) ? 4'b0010 : 4'b0000);
        end
        hold(4'b0000, 8);

        // Short low glitch on held channel 2
        hold(4'b0100, 8);
        chk("glitch_pre_level", o_btn_level, 4'b0100);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'b0000);
            chk("glitch_level", o_btn_level, 4'b0100);
            chk("glitch_release", o_btn_release, '0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b0100);
            chk("glitch_after_level", o_btn_level, 4'b0100);
            chk("glitch_after_release", o_btn_release, '0);
        end
        hold(4'b0000, 8);

        // Reset while channel 0 is pressed and channel 3 is mid-debounce
        hold(4'b0001, 8);
        hold(4'b1001, 5);
        chk("midrst_pre_level", o_btn_level, 4'b0001);
        @(negedge clock);
        i_ck_reset = 1'b0;
        model_reset();
        #1;
        chk("midrst_async_level", o_btn_level, '0);
        step(1'b0, 4'b1001);
        step(1'b0, 4'b1001);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 4'b1001);
            chk($sformatf("midrst_rel%0d_level", i), o_btn_level, (i >= 7) ? 4'b1001 : 4'b0000);
            chk($sformatf("midrst_rel%0d_press", i), o_btn_press, (i == 7) ? 4'b1001 : 4'b0000);
        end
        hold(4'b0000, 8);

        // Randomized traffic: per-bit toggles with runs mostly long enough to qualify
        begin
            logic [NB-1:0] cur;
            logic          rst;
            cur = '0;
            for (int n = 0; n < 3000; n++) begin
                for (int c = 0; c < NB; c++)
                    if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
                rst = ($urandom_range(0, 299) != 0);
                step(rst, cur);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
